// File: rtl/seq_pkg.sv
// Shared constants for the sequence detector: pattern-length limits and
// active-low 7-segment encodings (segment order gfedcba).
package seq_pkg;

  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 8;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {SEL_HEX, SEL_DASH, SEL_BLANK} seg_sel_e;

  function automatic seg_t hex_to_seg(input logic [3:0] d);
    case (d)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0010000;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b0000011;
      4'hC:    return 7'b1000110;
      4'hD:    return 7'b0100001;
      4'hE:    return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

endpackage

// File: rtl/seg7_lut.sv
// Active-low 7-segment lookup: hex digit, dash or blank.
module seg7_lut
  import seq_pkg::*;
(
  input  logic [3:0] digit,
  input  seg_sel_e   sel,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (sel)
      SEL_HEX:  seg = hex_to_seg(digit);
      SEL_DASH: seg = SEG_DASH;
      default:  seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seq_detector_param.sv
// Two-button serial bit entry with debouncing, parameterised pattern detector,
// match counter, LED hold timer and 7-segment status display.
module seq_detector_param
  import seq_pkg::*;
#(
  parameter int PAT_LEN  = 4,
  parameter     PATTERN  = 4'b1011,
  parameter int OVERLAP  = 1,
  parameter int DEBOUNCE = 1_000_000,
  parameter int LED_HOLD = 50_000_000
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_one,
  input  logic       btn_zero,
  output logic       Y,
  output logic       match,
  output logic [7:0] match_cnt,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);

  if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_len
    $error("seq_detector_param: PAT_LEN=%0d outside legal range", PAT_LEN);
  end
  if ($bits(PATTERN) != PAT_LEN) begin : g_bad_pat
    $error("seq_detector_param: PATTERN width %0d != PAT_LEN %0d", $bits(PATTERN), PAT_LEN);
  end
  if (DEBOUNCE < 1 || LED_HOLD < 1) begin : g_bad_timing
    $error("seq_detector_param: DEBOUNCE and LED_HOLD must be >= 1");
  end

  localparam int CW  = $clog2(PAT_LEN + 1);
  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam int HW  = $clog2(LED_HOLD + 1);
  localparam logic [PAT_LEN-1:0] PAT = PAT_LEN'(PATTERN);

  logic [1:0] btn_n, press;
  assign btn_n = {btn_one, btn_zero};

  // Index 1 enters a '1', index 0 a '0'; level 1 means released.
  for (genvar i = 0; i < 2; i++) begin : g_db
    logic [1:0]     sync;
    logic           db, pr;
    logic [DBW-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync <= 2'b11;
        db   <= 1'b1;
        cnt  <= '0;
        pr   <= 1'b0;
      end else begin
        sync <= {sync[0], btn_n[i]};
        pr   <= 1'b0;
        if (sync[1] == db) begin
          cnt <= '0;
        end else if (cnt == DBW'(DEBOUNCE - 1)) begin
          db  <= sync[1];
          cnt <= '0;
          pr  <= ~sync[1];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign press[i] = pr;
  end

  logic               bit_valid, bit_val, seen, hit;
  logic [PAT_LEN-1:0] hist, hist_nx;
  logic [CW-1:0]      vcnt, vcnt_nx;
  logic [HW-1:0]      hold;
  logic [3:0]         prog;

  assign hist_nx = {hist[PAT_LEN-2:0], bit_val};
  assign vcnt_nx = (vcnt == CW'(PAT_LEN)) ? vcnt : vcnt + 1'b1;
  assign hit     = bit_valid && (vcnt_nx == CW'(PAT_LEN)) && (hist_nx == PAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_valid <= 1'b0;
      bit_val   <= 1'b0;
      hist      <= '0;
      vcnt      <= '0;
      seen      <= 1'b0;
      match     <= 1'b0;
      match_cnt <= '0;
      hold      <= '0;
    end else begin
      // Simultaneous presses are ambiguous and dropped.
      bit_valid <= press[1] ^ press[0];
      bit_val   <= press[1];
      match     <= hit;
      if (bit_valid) begin
        hist <= hist_nx;
        vcnt <= (hit && OVERLAP == 0) ? '0 : vcnt_nx;
        seen <= 1'b1;
      end
      if (hit) match_cnt <= match_cnt + 8'd1;
      if (match)            hold <= HW'(LED_HOLD);
      else if (hold != '0) hold <= hold - 1'b1;
    end
  end

  assign Y = (hold != '0);

  function automatic logic head_match(input logic [PAT_LEN-1:0] h, input int k);
    logic [PAT_LEN-1:0] mask;
    mask = PAT_LEN'((32'd1 << k) - 32'd1);
    return (h & mask) == ((PAT >> (PAT_LEN - k)) & mask);
  endfunction

  // Longest proper prefix of the pattern that ends the valid history.
  always_comb begin
    prog = '0;
    for (int k = 1; k < PAT_LEN; k++) begin
      if (CW'(k) <= vcnt && head_match(hist, k)) prog = 4'(k);
    end
  end

  logic [3:0] hex0_digit;
  seg_sel_e   hex3_sel;

  always_comb begin
    hex0_digit = match ? 4'(PAT_LEN) : prog;
    hex3_sel   = seen ? SEL_HEX : SEL_DASH;
  end

  seg7_lut u_hex0 (.digit(hex0_digit),        .sel(SEL_HEX),  .seg(HEX0));
  seg7_lut u_hex1 (.digit(match_cnt[3:0]),    .sel(SEL_HEX),  .seg(HEX1));
  seg7_lut u_hex2 (.digit(match_cnt[7:4]),    .sel(SEL_HEX),  .seg(HEX2));
  seg7_lut u_hex3 (.digit({3'b000, hist[0]}), .sel(hex3_sel), .seg(HEX3));

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three configurations share the buttons; a
// queue-based reference model predicts matches, LED windows and display state.
module tb_seq_detector_param;

  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int ND   = 3;
  localparam int MAXC = 8192;

  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [6:0] DASH = 7'h3F;
  localparam bit DIR_BITS [7] = '{1, 0, 1, 1, 0, 1, 1};

  logic clk = 1'b0, rst = 1'b1, btn_one = 1'b1, btn_zero = 1'b1;
  logic [ND-1:0]      m_v, y_v;
  logic [ND-1:0][7:0] mc_v;
  logic [ND-1:0][6:0] h0_v, h1_v, h2_v, h3_v;

  always #5 clk = ~clk;

  seq_detector_param #(.DEBOUNCE(DEB), .LED_HOLD(HOLD)) u_ov (
    .clk(clk), .rst(rst), .btn_one(btn_one), .btn_zero(btn_zero), .Y(y_v[0]), .match(m_v[0]),
    .match_cnt(mc_v[0]), .HEX0(h0_v[0]), .HEX1(h1_v[0]), .HEX2(h2_v[0]), .HEX3(h3_v[0]));

  seq_detector_param #(.OVERLAP(0), .DEBOUNCE(DEB), .LED_HOLD(HOLD)) u_no (
    .clk(clk), .rst(rst), .btn_one(btn_one), .btn_zero(btn_zero), .Y(y_v[1]), .match(m_v[1]),
    .match_cnt(mc_v[1]), .HEX0(h0_v[1]), .HEX1(h1_v[1]), .HEX2(h2_v[1]), .HEX3(h3_v[1]));

  seq_detector_param #(.PAT_LEN(2), .PATTERN(2'b11), .DEBOUNCE(DEB), .LED_HOLD(HOLD)) u_p2 (
    .clk(clk), .rst(rst), .btn_one(btn_one), .btn_zero(btn_zero), .Y(y_v[2]), .match(m_v[2]),
    .match_cnt(mc_v[2]), .HEX0(h0_v[2]), .HEX1(h1_v[2]), .HEX2(h2_v[2]), .HEX3(h3_v[2]));

  // Reference model state
  int         plen [ND] = '{4, 4, 2};
  logic [7:0] ppat [ND] = '{8'b1011, 8'b1011, 8'b0000_0011};
  bit         povl [ND] = '{1'b1, 1'b0, 1'b1};
  bit         bits_q [ND][$];
  int         due_q  [ND][$];
  int         mcnt   [ND];
  bit         y_exp  [ND][MAXC];
  bit         seen_m, last_m;
  int         cyc = 0, errors = 0, checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // The newest k received bits equal the first k pattern bits.
  function automatic bit tail_eq(input int d, input int k);
    int n = bits_q[d].size();
    if (n < k) return 1'b0;
    for (int i = 0; i < k; i++)
      if (bits_q[d][n - k + i] != ppat[d][plen[d] - 1 - i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int progress(input int d);
    int p = 0;
    for (int k = 1; k < plen[d]; k++) if (tail_eq(d, k)) p = k;
    return p;
  endfunction

  task automatic accept(input bit b, input int due);
    seen_m = 1'b1;
    last_m = b;
    for (int d = 0; d < ND; d++) begin
      bits_q[d].push_back(b);
      if (bits_q[d].size() > plen[d]) void'(bits_q[d].pop_front());
      if (tail_eq(d, plen[d])) begin
        mcnt[d]++;
        due_q[d].push_back(due);
        for (int t = due + 1; t <= due + HOLD && t < MAXC; t++) y_exp[d][t] = 1'b1;
        if (!povl[d]) bits_q[d].delete();
      end
    end
  endtask

  task automatic model_reset();
    seen_m = 1'b0;
    for (int d = 0; d < ND; d++) begin
      bits_q[d].delete();
      due_q[d].delete();
      mcnt[d] = 0;
      for (int t = cyc; t < MAXC; t++) y_exp[d][t] = 1'b0;
    end
  endtask

  // Monitor: match pulses and LED level against the predicted schedule.
  always @(negedge clk) begin
    if (!rst && cyc < MAXC) begin
      for (int d = 0; d < ND; d++) begin
        bit em;
        em = (due_q[d].size() != 0) && (due_q[d][0] == cyc);
        chk($sformatf("match[%0d]", d), {7'd0, m_v[d]}, {7'd0, em});
        if (em) begin
          void'(due_q[d].pop_front());
          chk($sformatf("hex0_at_match[%0d]", d), {1'b0, h0_v[d]}, {1'b0, SEG[plen[d]]});
        end
        chk($sformatf("Y[%0d]", d), {7'd0, y_v[d]}, {7'd0, y_exp[d][cyc]});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit one, input bit zero, input int lo, input int hi);
    if (one)  btn_one  = 1'b0;
    if (zero) btn_zero = 1'b0;
    tick(lo);
    btn_one  = 1'b1;
    btn_zero = 1'b1;
    tick(hi);
  endtask

  // A press held >= DEB cycles shows up as match 8 cycles after the drive.
  task automatic enter(input bit b, input int lo, input int hi);
    accept(b, cyc + 8);
    press(b, !b, lo, hi);
  endtask

  task automatic check_state(input string tag);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("%s hex0[%0d]", tag, d), {1'b0, h0_v[d]}, {1'b0, SEG[progress(d)]});
      chk($sformatf("%s hex3[%0d]", tag, d), {1'b0, h3_v[d]}, {1'b0, seen_m ? SEG[int'(last_m)] : DASH});
      chk($sformatf("%s hex1[%0d]", tag, d), {1'b0, h1_v[d]}, {1'b0, SEG[mcnt[d] % 16]});
      chk($sformatf("%s hex2[%0d]", tag, d), {1'b0, h2_v[d]}, {1'b0, SEG[(mcnt[d] / 16) % 16]});
      chk($sformatf("%s cnt[%0d]", tag, d), mc_v[d], 8'(mcnt[d] % 256));
    end
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    model_reset();
    tick(n);
    rst = 1'b0;
  endtask

  initial begin
    tick(3);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst match[%0d]", d), {7'd0, m_v[d]}, 8'd0);
      chk($sformatf("rst Y[%0d]", d), {7'd0, y_v[d]}, 8'd0);
      chk($sformatf("rst cnt[%0d]", d), mc_v[d], 8'd0);
      chk($sformatf("rst hex3[%0d]", d), {1'b0, h3_v[d]}, {1'b0, DASH});
      chk($sformatf("rst hex0[%0d]", d), {1'b0, h0_v[d]}, {1'b0, SEG[0]});
    end
    rst = 1'b0;
    tick(2);

    // Directed stream 1,0,1,1,0,1,1
    for (int i = 0; i < 7; i++) begin
      enter(DIR_BITS[i], 6, 10);
      check_state("dir");
      if (i == 3) chk("dir_prog_after_4th", {1'b0, h0_v[0]}, {1'b0, SEG[1]});
    end
    chk("dir_ovl_cnt", mc_v[0], 8'd2);
    chk("dir_novl_cnt", mc_v[1], 8'd1);

    // Debounce edge: 3-cycle glitch rejected, 4-cycle low accepted
    press(1'b1, 1'b0, 3, 8);
    check_state("glitch3");
    enter(1'b1, 4, 12);
    check_state("low4");

    // Both buttons in the same cycle are ignored
    press(1'b1, 1'b1, 6, 10);
    check_state("both");

    // Random entry with occasional sub-threshold glitches
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        bit one = 1'($urandom_range(0, 1));
        press(one, !one, $urandom_range(1, DEB - 1), DEB);
      end else begin
        enter(1'($urandom_range(0, 1)), $urandom_range(DEB, DEB + 3), $urandom_range(DEB + 6, DEB + 9));
      end
      check_state("rand");
    end

    // Back-to-back matches on the 2-bit "11" detector: hold restarts, count wraps
    pulse_reset(2);
    tick(2);
    while (mcnt[2] < 256) enter(1'b1, 4, 4);
    tick(14);
    check_state("wrap");
    chk("wrap256_cnt", mc_v[2], 8'd0);

    // Reset in the middle of an LED window
    enter(1'b1, 4, 4);
    tick(3);
    pulse_reset(2);
    tick(2);

    // 1,0,1 then reset while the 4th '1' is about to be accepted
    enter(1'b1, 6, 10);
    enter(1'b0, 6, 10);
    enter(1'b1, 6, 10);
    check_state("pre_abort");
    btn_one = 1'b0;
    tick(6);
    btn_one = 1'b1;
    pulse_reset(2);
    tick(10);
    check_state("post_abort");
    chk("abort_hex3_dash", {1'b0, h3_v[0]}, {1'b0, DASH});
    enter(1'b1, 6, 10);
    check_state("single1");

    // Button held through reset registers as exactly one press
    rst = 1'b1;
    btn_one = 1'b0;
    model_reset();
    tick(3);
    rst = 1'b0;
    accept(1'b1, cyc + 8);
    tick(10);
    btn_one = 1'b1;
    tick(12);
    check_state("held_rst");

    tick(15);
    for (int d = 0; d < ND; d++)
      chk($sformatf("pending_matches[%0d]", d), 8'(due_q[d].size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
